// File: rtl/grf.sv
// 32 x DATA_W general register file: one W-stage write port, two bypassed combinational read ports, retired-write counter.
// Define GRF_TRACE_EN to print one simulation trace line per effective write.
module grf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              W_RegWrite,
    input  logic [4:0]        W_RegAddr,
    input  logic [DATA_W-1:0] W_RegData,
    input  logic [31:0]       W_PC,
    output logic [CNT_W-1:0]  WrCount
);

    logic [DATA_W-1:0] r_regs [0:31];
    logic [CNT_W-1:0]  r_wrcount;
    logic              w_we;
    logic              w_unused_pc;

    assign w_we        = W_RegWrite && (W_RegAddr != 5'd0);
    assign w_unused_pc = ^W_PC;
    assign WrCount     = r_wrcount;

    // Reset wins over a coincident write; entry 0 is never written and never read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_wrcount <= '0;
        end else if (w_we) begin
            r_regs[W_RegAddr] <= W_RegData;
            r_wrcount         <= r_wrcount + CNT_W'(1);
        end
    end

    // The bypass deliberately ignores reset so D sees the in-flight W value.
    always_comb begin
        RD1 = r_regs[A1];
        if (A1 == 5'd0) begin
            RD1 = '0;
        end else if (W_RegWrite && (W_RegAddr == A1)) begin
            RD1 = W_RegData;
        end
    end

    always_comb begin
        RD2 = r_regs[A2];
        if (A2 == 5'd0) begin
            RD2 = '0;
        end else if (W_RegWrite && (W_RegAddr == A2)) begin
            RD2 = W_RegData;
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            $display("@%08h: $%2d <= %08h", W_PC, W_RegAddr, W_RegData);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf.sv
// Randomized self-checking bench for grf: array-based reference model, per-cycle compare on negedge, directed literal checks.
module tb_grf;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    A1, A2;
    logic [DW-1:0] RD1, RD2;
    logic          W_RegWrite;
    logic [4:0]    W_RegAddr;
    logic [DW-1:0] W_RegData;
    logic [31:0]   W_PC;
    logic [CW-1:0] WrCount;

    grf #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .W_RegWrite(W_RegWrite), .W_RegAddr(W_RegAddr), .W_RegData(W_RegData),
        .W_PC(W_PC), .WrCount(WrCount)
    );

    always #5 clk = ~clk;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    bit            checking = 1'b0;
    logic [DW-1:0] m_regs [32];
    int unsigned   m_cnt;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (W_RegWrite === 1'b1 && W_RegAddr == a) return W_RegData;
        return m_regs[a];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [DW-1:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        reset = rst; W_RegWrite = we; W_RegAddr = wa; W_RegData = wd;
        A1 = a1; A2 = a2; W_PC = W_PC + 32'd4;
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic tick;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = 0;
        end else if (W_RegWrite && W_RegAddr != 0) begin
            m_regs[W_RegAddr] = W_RegData;
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
        checking = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("rd1_model", RD1, exp_rd(A1));
            chk("rd2_model", RD2, exp_rd(A2));
            chk("wrcount_model", DW'(WrCount), DW'(m_cnt));
        end
    end

    initial begin
        logic [4:0] a, b;
        W_PC = 32'h0000_2ffc;
        for (int i = 0; i < 32; i++) m_regs[i] = 'x;
        m_cnt = 0;
        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        tick; tick;

        // Every address reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
            #1;
            chk("reset_rd1", RD1, '0);
            chk("reset_rd2", RD2, '0);
            tick;
        end
        chk("reset_cnt", DW'(WrCount), '0);

        W_PC = 32'h0000_2ffc;
        drive(1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd0);
        tick;
        drive(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd0);
        #1;
        chk("wr5_rd1", RD1, 32'h1234_5678);
        chk("wr5_cnt", DW'(WrCount), 32'd1);
        tick;

        drive(1'b0, 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
        tick;
        drive(1'b0, 1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
        #1;
        chk("bypass_rd1", RD1, 32'h22);
        chk("bypass_rd2", RD2, 32'h22);
        tick;
        drive(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd9);
        #1;
        chk("after_bypass", RD1, 32'h22);
        tick;

        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        chk("r0_before", RD1, '0);
        tick;
        drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        #1;
        chk("r0_after", RD1, '0);
        chk("r0_cnt", DW'(WrCount), 32'd3);
        tick;

        drive(1'b1, 1'b1, 5'd3, 32'hDEAD, 5'd3, 5'd0);
        tick;
        drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd0);
        #1;
        chk("rst_wr_lost", RD1, '0);
        chk("rst_wr_cnt", DW'(WrCount), '0);
        tick;
        drive(1'b0, 1'b1, 5'd3, 32'hBEEF, 5'd0, 5'd0);
        tick;
        drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd0);
        #1;
        chk("beef_rd1", RD1, 32'hBEEF);
        chk("beef_cnt", DW'(WrCount), 32'd1);
        tick;

        // Counter wrap with idle cycles interleaved.
        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        tick;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 5'(1 + i), $urandom, 5'd0, 5'd0);
            tick;
            drive(1'b0, 1'b0, 5'(1 + i), $urandom, 5'd0, 5'd0);
            tick;
            if (i == 7) chk("cnt_mid", DW'(WrCount), 32'd8);
        end
        chk("cnt_wrap", DW'(WrCount), '0);

        for (int n = 0; n < 3000; n++) begin
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                  a, ($urandom_range(0, 3) == 0) ? a : b);
            tick;
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
